// File: rtl/sisc_pkg.sv
// Shared SISC definitions: FSM phase encoding, opcodes, mode constants and
// the protocol error codes reported by the control-bus monitor.
package sisc_pkg;

  typedef enum logic [2:0] {
    PH_SYNC    = 3'd0,
    PH_START   = 3'd1,
    PH_FETCH   = 3'd2,
    PH_DECODE  = 3'd3,
    PH_EXECUTE = 3'd4,
    PH_MEM     = 3'd5,
    PH_WB      = 3'd6
  } phase_e;

  localparam logic [3:0] NOOP   = 4'd0;
  localparam logic [3:0] LOD    = 4'd1;
  localparam logic [3:0] STR    = 4'd2;
  localparam logic [3:0] SWP    = 4'd3;
  localparam logic [3:0] BRA    = 4'd4;
  localparam logic [3:0] BRR    = 4'd5;
  localparam logic [3:0] BNE    = 4'd6;
  localparam logic [3:0] BNR    = 4'd7;
  localparam logic [3:0] ALU_OP = 4'd8;
  localparam logic [3:0] HLT    = 4'd15;

  localparam logic [3:0] AM_IMM = 4'd8;

  // mm values that make a register-file write legal in MEM / WB
  localparam logic [3:0] MM_RF_MEM = 4'd9;
  localparam logic [3:0] MM_RF_WB  = 4'd1;

  localparam logic [2:0] ERR_NONE = 3'd0;
  localparam logic [2:0] ERR_IR   = 3'd1;
  localparam logic [2:0] ERR_PC   = 3'd2;
  localparam logic [2:0] ERR_DM   = 3'd3;
  localparam logic [2:0] ERR_RF   = 3'd4;
  localparam logic [2:0] ERR_BR   = 3'd5;

  function automatic logic is_branch(input logic [3:0] op);
    return (op == BRA) || (op == BRR) || (op == BNE) || (op == BNR);
  endfunction

endpackage

// File: rtl/ctrl_rule_check.sv
// Combinational strobe checker: maps one sampled bus cycle to the
// lowest-numbered protocol violation, or ERR_NONE.
module ctrl_rule_check
  import sisc_pkg::*;
(
  input  logic [2:0] phase,
  input  logic [3:0] opcode,
  input  logic [3:0] mm,
  input  logic [3:0] stat,
  input  logic       ir_load,
  input  logic       pc_write,
  input  logic       rf_we,
  input  logic       dm_we,
  output logic [2:0] fail_code
);

  logic is_fetch;
  logic is_decode;
  logic is_mem;
  logic is_wb;
  logic branch;
  logic taken;
  logic pc_bad;
  logic dm_bad;
  logic rf_ok;
  logic rf_bad;
  logic br_bad;

  always_comb begin
    is_fetch  = (phase == PH_FETCH);
    is_decode = (phase == PH_DECODE);
    is_mem    = (phase == PH_MEM);
    is_wb     = (phase == PH_WB);
    branch    = is_branch(opcode);

    // BRA/BRR take on any selected flag set, BNE/BNR on none set
    if ((opcode == BRA) || (opcode == BRR)) begin
      taken = |(mm & stat);
    end else begin
      taken = ~|(mm & stat);
    end

    if (pc_write) begin
      pc_bad = !(is_fetch || is_decode) || (is_decode && !branch);
    end else begin
      pc_bad = is_fetch;
    end

    dm_bad = dm_we && !(is_mem && (opcode == STR));

    rf_ok = (is_mem && ((opcode == LOD) || (opcode == SWP) ||
                        ((opcode == STR) && (mm == MM_RF_MEM)))) ||
            (is_wb  && ((opcode == ALU_OP) || (opcode == SWP) ||
                        (((opcode == LOD) || (opcode == STR)) && (mm == MM_RF_WB)) ||
                        ((opcode == LOD) && (mm == MM_RF_MEM))));
    rf_bad = rf_we && !rf_ok;

    br_bad = is_decode && branch && (pc_write != taken);

    fail_code = ERR_NONE;
    if (ir_load != is_fetch) begin
      fail_code = ERR_IR;
    end else if (pc_bad) begin
      fail_code = ERR_PC;
    end else if (dm_bad) begin
      fail_code = ERR_DM;
    end else if (rf_bad) begin
      fail_code = ERR_RF;
    end else if (br_bad) begin
      fail_code = ERR_BR;
    end
  end

endmodule

// File: rtl/ctrl_bus_monitor.sv
// Passive SISC control-bus monitor: tracks the FSM phase, checks strobes,
// counts retired instructions and taken branches, latches the first error.
module ctrl_bus_monitor
  import sisc_pkg::*;
#(
  parameter int CNT_W = 16,
  parameter int ERR_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       opcode,
  input  logic [3:0]       mm,
  input  logic [3:0]       stat,
  input  logic             pc_rst,
  input  logic             pc_write,
  input  logic             pc_sel,
  input  logic             ir_load,
  input  logic             rf_we,
  input  logic             dm_we,
  input  logic [1:0]       wb_sel,
  output logic [2:0]       phase,
  output logic [CNT_W-1:0] instr_cnt,
  output logic [CNT_W-1:0] br_cnt,
  output logic             halted,
  output logic             err,
  output logic [ERR_W-1:0] err_code
);

  phase_e           phase_q, phase_d;
  logic [CNT_W-1:0] instr_cnt_q, instr_cnt_d;
  logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
  logic             halted_q, halted_d;
  logic             err_q, err_d;
  logic [ERR_W-1:0] err_code_q, err_code_d;
  logic [2:0]       fail_code;
  logic             check_en;
  logic             unused_wb_sel;

  assign unused_wb_sel = ^wb_sel;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  ctrl_rule_check u_rule_check (
    .phase     (phase_q),
    .opcode    (opcode),
    .mm        (mm),
    .stat      (stat),
    .ir_load   (ir_load),
    .pc_write  (pc_write),
    .rf_we     (rf_we),
    .dm_we     (dm_we),
    .fail_code (fail_code)
  );

  always_comb begin
    phase_d     = phase_q;
    instr_cnt_d = instr_cnt_q;
    br_cnt_d    = br_cnt_q;
    halted_d    = halted_q;
    err_d       = err_q;
    err_code_d  = err_code_q;

    // a re-sync cycle is exempt from checking
    check_en = !pc_rst && !halted_q &&
               (phase_q != PH_SYNC) && (phase_q != PH_START);

    if (check_en && !err_q && (fail_code != ERR_NONE)) begin
      err_d      = 1'b1;
      err_code_d = ERR_W'(fail_code);
    end

    if (!halted_q) begin
      if (phase_q == PH_WB) begin
        instr_cnt_d = sat_inc(instr_cnt_q);
      end
      if ((phase_q == PH_DECODE) && pc_write && pc_sel && is_branch(opcode)) begin
        br_cnt_d = sat_inc(br_cnt_q);
      end
    end

    if ((phase_q == PH_DECODE) && (opcode == HLT)) begin
      halted_d = 1'b1;
    end

    case (phase_q)
      PH_SYNC:    phase_d = pc_rst ? PH_START : PH_SYNC;
      PH_START:   phase_d = PH_FETCH;
      PH_FETCH:   phase_d = PH_DECODE;
      PH_DECODE:  phase_d = PH_EXECUTE;
      PH_EXECUTE: phase_d = PH_MEM;
      PH_MEM:     phase_d = PH_WB;
      PH_WB:      phase_d = PH_FETCH;
      default:    phase_d = PH_SYNC;
    endcase
    if (pc_rst && (phase_q != PH_SYNC)) begin
      phase_d = PH_FETCH;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q     <= PH_SYNC;
      instr_cnt_q <= '0;
      br_cnt_q    <= '0;
      halted_q    <= 1'b0;
      err_q       <= 1'b0;
      err_code_q  <= '0;
    end else begin
      phase_q     <= phase_d;
      instr_cnt_q <= instr_cnt_d;
      br_cnt_q    <= br_cnt_d;
      halted_q    <= halted_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
    end
  end

  assign phase     = phase_q;
  assign instr_cnt = instr_cnt_q;
  assign br_cnt    = br_cnt_q;
  assign halted    = halted_q;
  assign err       = err_q;
  assign err_code  = err_code_q;

endmodule

// File: tb/tb_ctrl_bus_monitor.sv
// Scoreboard bench for ctrl_bus_monitor: directed scenarios then randomized
// instruction streams, compared against a behavioural bus model.
module tb_ctrl_bus_monitor;

  localparam int CNT_W = 4;
  localparam int MAXC  = (1 << CNT_W) - 1;

  typedef struct packed {
    logic       pc_rst;
    logic       pc_write;
    logic       pc_sel;
    logic       ir_load;
    logic       rf_we;
    logic       dm_we;
    logic [1:0] wb_sel;
  } ctrl_t;

  typedef struct packed {
    logic [2:0]       ph;
    logic [CNT_W-1:0] ic;
    logic [CNT_W-1:0] bc;
    logic             h;
    logic             e;
    logic [2:0]       ec;
  } exp_t;

  localparam logic [7:0] M_PW = 8'b0100_0000;
  localparam logic [7:0] M_PS = 8'b0010_0000;
  localparam logic [7:0] M_IR = 8'b0001_0000;
  localparam logic [7:0] M_DM = 8'b0000_0100;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [3:0]       opcode = '0, mm = '0, stat = '0;
  logic             pc_rst = 1'b0, pc_write = 1'b0, pc_sel = 1'b0;
  logic             ir_load = 1'b0, rf_we = 1'b0, dm_we = 1'b0;
  logic [1:0]       wb_sel = '0;
  logic [2:0]       phase;
  logic [CNT_W-1:0] instr_cnt, br_cnt;
  logic             halted, err;
  logic [2:0]       err_code;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  int m_ph = 0, m_ic = 0, m_bc = 0, m_ec = 0;
  bit m_h = 0, m_e = 0;

  always #5 clk = ~clk;

  ctrl_bus_monitor #(.CNT_W(CNT_W), .ERR_W(3)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mm(mm), .stat(stat),
    .pc_rst(pc_rst), .pc_write(pc_write), .pc_sel(pc_sel), .ir_load(ir_load),
    .rf_we(rf_we), .dm_we(dm_we), .wb_sel(wb_sel), .phase(phase),
    .instr_cnt(instr_cnt), .br_cnt(br_cnt), .halted(halted), .err(err),
    .err_code(err_code)
  );

  function automatic bit is_br(input int op);
    return op >= 4 && op <= 7;
  endfunction

  function automatic bit br_taken(input int op, input logic [3:0] m, input logic [3:0] s);
    int hits = 0;
    for (int i = 0; i < 4; i++) if (m[i] && s[i]) hits++;
    return (op <= 5) ? (hits > 0) : (hits == 0);
  endfunction

  function automatic bit rf_allowed(input int ph, input int op, input int m);
    if (ph == 5) return op == 1 || op == 3 || (op == 2 && m == 9);
    if (ph == 6) return op == 8 || op == 3 || ((op == 1 || op == 2) && m == 1) || (op == 1 && m == 9);
    return 0;
  endfunction

  // Overwrite from highest to lowest code so the smallest applicable code remains.
  function automatic int rule_code(input int ph, input int op, input logic [3:0] m,
                                   input logic [3:0] s, input ctrl_t c);
    int code = 0;
    if (ph == 3 && is_br(op) && c.pc_write != br_taken(op, m, s)) code = 5;
    if (c.rf_we && !rf_allowed(ph, op, m)) code = 4;
    if (c.dm_we && !(ph == 5 && op == 2)) code = 3;
    if ((c.pc_write && ph != 2 && ph != 3) || (ph == 2 && !c.pc_write) ||
        (ph == 3 && c.pc_write && !is_br(op))) code = 2;
    if (c.ir_load != (ph == 2)) code = 1;
    return code;
  endfunction

  function automatic ctrl_t legal(input int ph, input int op, input logic [3:0] m,
                                  input logic [3:0] s);
    ctrl_t c = '0;
    c.wb_sel = 2'($urandom_range(0, 3));
    case (ph)
      2: begin c.ir_load = 1; c.pc_write = 1; end
      3: if (is_br(op) && br_taken(op, m, s)) begin c.pc_write = 1; c.pc_sel = 1; end
      5: begin c.dm_we = (op == 2); c.rf_we = rf_allowed(5, op, m); end
      6: c.rf_we = rf_allowed(6, op, m);
      default: ;
    endcase
    return c;
  endfunction

  task automatic model_step(input bit r, input ctrl_t c, input int op,
                            input logic [3:0] m, input logic [3:0] s);
    exp_t x;
    if (r) begin
      m_ph = 0; m_ic = 0; m_bc = 0; m_h = 0; m_e = 0; m_ec = 0;
    end else begin
      int  code = 0;
      bit  nh;
      if (m_ph >= 2 && !m_h && !c.pc_rst) code = rule_code(m_ph, op, m, s, c);
      if (code != 0 && !m_e) begin m_e = 1; m_ec = code; end
      nh = m_h || (m_ph == 3 && op == 15);
      if (!m_h && m_ph == 6 && m_ic < MAXC) m_ic++;
      if (!m_h && m_ph == 3 && c.pc_write && c.pc_sel && is_br(op) && m_bc < MAXC) m_bc++;
      m_h = nh;
      if (c.pc_rst) m_ph = (m_ph == 0) ? 1 : 2;
      else if (m_ph == 0) m_ph = 0;
      else if (m_ph == 1 || m_ph == 6) m_ph = 2;
      else m_ph = m_ph + 1;
    end
    x.ph = 3'(m_ph); x.ic = CNT_W'(m_ic); x.bc = CNT_W'(m_bc);
    x.h = m_h; x.e = m_e; x.ec = 3'(m_ec);
    exp_q.push_back(x);
  endtask

  task automatic cyc(input bit r, input ctrl_t c, input int op,
                     input logic [3:0] m, input logic [3:0] s);
    @(negedge clk);
    rst = r; opcode = 4'(op); mm = m; stat = s;
    pc_rst = c.pc_rst; pc_write = c.pc_write; pc_sel = c.pc_sel;
    ir_load = c.ir_load; rf_we = c.rf_we; dm_we = c.dm_we; wb_sel = c.wb_sel;
    model_step(r, c, op, m, s);
  endtask

  task automatic do_reset();
    cyc(1, '0, 0, 4'd0, 4'd0);
  endtask

  task automatic do_sync();
    ctrl_t c = '0;
    c.pc_rst = 1;
    cyc(0, c, 0, 4'd0, 4'd0);
    cyc(0, '0, 0, 4'd0, 4'd0);
  endtask

  // One instruction FETCH..WB; mask flips strobes in phase fph, rph aborts with pc_rst.
  task automatic instr(input int op, input logic [3:0] m, input logic [3:0] s,
                       input int fph, input logic [7:0] mask, input int rph);
    ctrl_t c;
    for (int ph = 2; ph <= 6; ph++) begin
      c = legal(ph, op, m, s);
      if (ph == fph) c = ctrl_t'(c ^ mask);
      if (ph == rph) c.pc_rst = 1;
      cyc(0, c, op, m, s);
      if (ph == rph) break;
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (phase !== e.ph || instr_cnt !== e.ic || br_cnt !== e.bc ||
            halted !== e.h || err !== e.e || err_code !== e.ec) begin
          errors++;
          $display("FAIL outputs @%0t: got ph=%0d ic=%0d bc=%0d h=%0d e=%0d ec=%0d, want ph=%0d ic=%0d bc=%0d h=%0d e=%0d ec=%0d",
                   $time, phase, instr_cnt, br_cnt, halted, err, err_code,
                   e.ph, e.ic, e.bc, e.h, e.e, e.ec);
        end
      end
    end
  end

  initial begin : stimulus
    int ops[10] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 8};
    int op, n, fph, rph, wait_cnt;
    logic [3:0] m, s;
    logic [7:0] mask;
    ctrl_t c;

    // ALU retire, branch taken, then a bad branch decision
    do_reset(); do_sync();
    instr(8, 4'd0, 4'd0, 0, 8'h00, 0);
    instr(6, 4'b0001, 4'b0000, 0, 8'h00, 0);
    instr(6, 4'b0001, 4'b0001, 3, M_PW | M_PS, 0);
    // data-memory write out of place, later IR fault must not overwrite it
    do_reset(); do_sync();
    instr(2, 4'd0, 4'd0, 4, M_DM, 0);
    instr(8, 4'd0, 4'd0, 2, M_IR, 0);
    // IR and PC faults together: IR has priority
    do_reset(); do_sync();
    instr(8, 4'd0, 4'd0, 2, M_IR | M_PW, 0);
    // halt freezes counters
    do_reset(); do_sync();
    instr(15, 4'd0, 4'd0, 0, 8'h00, 0);
    instr(8, 4'd0, 4'd0, 0, 8'h00, 0);
    instr(8, 4'd0, 4'd0, 2, M_IR, 0);
    do_reset();
    // saturation and mid-instruction re-sync
    do_sync();
    for (int i = 0; i < 17; i++) instr(8, 4'd0, 4'd0, 0, 8'h00, 0);
    instr(8, 4'd0, 4'd0, 0, 8'h00, 4);
    instr(1, 4'd9, 4'd0, 0, 8'h00, 0);

    for (int ep = 0; ep < 60; ep++) begin
      do_reset();
      n = $urandom_range(0, 2);
      for (int i = 0; i < n; i++) begin
        c = ctrl_t'(8'($urandom));
        c.pc_rst = 0;
        cyc(0, c, $urandom_range(0, 15), 4'($urandom), 4'($urandom));
      end
      do_sync();
      n = $urandom_range(4, 20);
      for (int i = 0; i < n; i++) begin
        op = ($urandom_range(0, 29) == 0) ? 15 : ops[$urandom_range(0, 9)];
        case ($urandom_range(0, 3))
          0: m = 4'd1;
          1: m = 4'd9;
          default: m = 4'($urandom);
        endcase
        s = 4'($urandom);
        fph = 0; mask = 8'h00; rph = 0;
        if ($urandom_range(0, 24) == 0) begin
          fph = $urandom_range(2, 6);
          mask = {1'b0, 5'($urandom_range(1, 31)), 2'b00};
        end
        if ($urandom_range(0, 29) == 0) rph = $urandom_range(2, 6);
        instr(op, m, s, fph, mask, rph);
      end
    end

    wait_cnt = 0;
    while (exp_q.size() > 0 && wait_cnt < 10) begin
      @(posedge clk);
      #2;
      wait_cnt++;
    end
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
